// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared widths, types and helpers for the register-file write-back front end.
package regfile_writeback_arbiter_pkg;

    localparam int XLEN     = 32;
    localparam int RAW      = 5;
    localparam int NUM_REGS = 2 ** RAW;
    localparam int DEPTH    = 4;

    typedef logic [RAW-1:0]  reg_addr_t;
    typedef logic [XLEN-1:0] xword_t;

    typedef struct packed {
        reg_addr_t rd;
        xword_t    data;
        logic      dvalid;
    } lq_entry_t;

    // x0 is hardwired, so it can never be busy.
    function automatic logic reg_busy(input logic [NUM_REGS-1:0] busy, input reg_addr_t r);
        return (r != '0) && busy[r];
    endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Pipeline-facing signals of the write-back arbiter: execute, load issue/return, decode, file port.
interface regfile_writeback_arbiter_if;
    import regfile_writeback_arbiter_pkg::*;

    logic      ex_we;
    reg_addr_t ex_rd;
    xword_t    ex_wd;
    logic      ld_issue;
    reg_addr_t ld_rd;
    logic      ld_ready;
    logic      mem_valid;
    xword_t    mem_rdata;
    reg_addr_t dec_rs1;
    reg_addr_t dec_rs2;
    reg_addr_t dec_rd;
    logic      hazard;
    logic      rf_we;
    reg_addr_t rf_a3;
    xword_t    rf_wd;
    reg_addr_t pend_cnt;
    logic      err;

    modport master (
        output ex_we, ex_rd, ex_wd, ld_issue, ld_rd, mem_valid, mem_rdata,
               dec_rs1, dec_rs2, dec_rd,
        input  ld_ready, hazard, rf_we, rf_a3, rf_wd, pend_cnt, err
    );

    modport slave (
        input  ex_we, ex_rd, ex_wd, ld_issue, ld_rd, mem_valid, mem_rdata,
               dec_rs1, dec_rs2, dec_rd,
        output ld_ready, hazard, rf_we, rf_a3, rf_wd, pend_cnt, err
    );

endinterface

// File: rtl/regfile_writeback_arbiter_load_queue.sv
// In-order load queue: issue (wr), response (rsp) and drain (rd) pointers with an extra wrap bit.
module regfile_writeback_arbiter_load_queue
    import regfile_writeback_arbiter_pkg::*;
#(
    parameter int QDEPTH = DEPTH
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       push,
    input  reg_addr_t                  push_rd,
    input  logic                       rsp_valid,
    input  xword_t                     rsp_data,
    input  logic                       pop,
    output logic                       ready,
    output logic                       rsp_stray,
    output lq_entry_t                  head,
    output logic [$clog2(QDEPTH):0]    count
);

    localparam int IDX_W = $clog2(QDEPTH);
    typedef logic [IDX_W:0] ptr_t;

    ptr_t               wr_ptr, rsp_ptr, rd_ptr;
    reg_addr_t          slot_rd   [QDEPTH];
    xword_t             slot_data [QDEPTH];
    logic [QDEPTH-1:0]  dvalid;
    logic [IDX_W-1:0]   widx, ridx, hidx;
    logic               do_push, do_rsp, do_pop;

    assign widx = wr_ptr[IDX_W-1:0];
    assign ridx = rsp_ptr[IDX_W-1:0];
    assign hidx = rd_ptr[IDX_W-1:0];

    assign count     = wr_ptr - rd_ptr;
    assign ready     = (count != ptr_t'(QDEPTH));
    // A response with every issued load already answered has no owner.
    assign rsp_stray = rsp_valid && (rsp_ptr == wr_ptr);

    assign do_push = push && ready;
    assign do_rsp  = rsp_valid && !rsp_stray;
    assign head    = '{rd: slot_rd[hidx], data: slot_data[hidx],
                       dvalid: (rd_ptr != wr_ptr) && dvalid[hidx]};
    assign do_pop  = pop && head.dvalid;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr  <= '0;
            rsp_ptr <= '0;
            rd_ptr  <= '0;
            dvalid  <= '0;
        end else begin
            if (do_push) begin
                dvalid[widx] <= 1'b0;
                wr_ptr       <= wr_ptr + ptr_t'(1);
            end
            if (do_rsp) begin
                dvalid[ridx] <= 1'b1;
                rsp_ptr      <= rsp_ptr + ptr_t'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

    // NOTE: payload storage has no reset; the pointers and dvalid decide what is meaningful.
    always_ff @(posedge CLK) begin
        if (do_push) slot_rd[widx]   <= push_rd;
        if (do_rsp)  slot_data[ridx] <= rsp_data;
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-port arbiter: execute beats load drain; scoreboard of pending load targets.
module regfile_writeback_arbiter
    import regfile_writeback_arbiter_pkg::*;
(
    input  logic                        CLK,
    input  logic                        RST,
    regfile_writeback_arbiter_if.slave  bus
);

    lq_entry_t              head;
    logic                   ready, rsp_stray, pop, ex_hit, push_ok;
    logic [$clog2(DEPTH):0] count;
    logic [NUM_REGS-1:0]    busy;
    logic                   err_q;

    regfile_writeback_arbiter_load_queue #(.QDEPTH(DEPTH)) u_queue (
        .CLK       (CLK),
        .RST       (RST),
        .push      (bus.ld_issue),
        .push_rd   (bus.ld_rd),
        .rsp_valid (bus.mem_valid),
        .rsp_data  (bus.mem_rdata),
        .pop       (pop),
        .ready     (ready),
        .rsp_stray (rsp_stray),
        .head      (head),
        .count     (count)
    );

    assign push_ok = bus.ld_issue && ready;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        ex_hit     = RST && bus.ex_we && (bus.ex_rd != '0);
        pop        = 1'b0;
        bus.rf_we  = 1'b0;
        bus.rf_a3  = '0;
        bus.rf_wd  = '0;
        if (ex_hit) begin
            bus.rf_we = 1'b1;
            bus.rf_a3 = bus.ex_rd;
            bus.rf_wd = bus.ex_wd;
        end else if (head.dvalid) begin
            pop       = 1'b1;
            bus.rf_we = (head.rd != '0);
            bus.rf_a3 = head.rd;
            bus.rf_wd = head.data;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            busy  <= '0;
            err_q <= 1'b0;
        end else begin
            if (pop) busy[head.rd] <= 1'b0;
            // Placed after the clear so a same-cycle set on the same register wins.
            if (push_ok && (bus.ld_rd != '0)) busy[bus.ld_rd] <= 1'b1;
            if (rsp_stray) err_q <= 1'b1;
        end
    end

    assign bus.hazard   = reg_busy(busy, bus.dec_rs1) | reg_busy(busy, bus.dec_rs2)
                        | reg_busy(busy, bus.dec_rd);
    assign bus.ld_ready = ready;
    assign bus.pend_cnt = reg_addr_t'(count);
    assign bus.err      = err_q;

endmodule
